dvp_frame_gen: RTL
==================

Name: dvp_frame_gen

Overview:
- Synthesizable DVP (OV5640-style) transmitter: generates vsync/href/8-bit RGB565 byte stream with test patterns.
- Stands in for the camera at the capture input, so the capture -> SDRAM -> VGA/ISP path can be exercised without a sensor, in simulation and on board.
- Runs in the pixel-clock domain of the capture block; the output directly replaces cmos_vsync/cmos_href/cmos_data.

Parameters:
- H_DISP, 640, active pixels per line; must be a multiple of 8.
- V_DISP, 480, active lines per frame.
- H_BLANK, 144, href-low clocks per line after active bytes.
- VS_WIDTH, 4, vsync-high lines per frame.
- V_BACK, 16, blank lines between vsync and first active line.
- V_FRONT, 8, blank lines after last active line.

Ports:
- clk  in  1  pixel/byte clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- en  in  1  level; frame generation allowed while high.
- pattern_sel  in  2  0 colour bars, 1 gray ramp, 2 checkerboard, 3 solid red.
- dvp_vsync  out  1  frame sync, active-high.
- dvp_href  out  1  line valid, active-high.
- dvp_data  out  8  RGB565 byte, high byte first.
- frame_done  out  1  one-cycle pulse on the last clock of a frame.
- frame_cnt  out  8  completed-frame count; wraps.

Behaviour:
- LINE_LEN = 2*H_DISP + H_BLANK clocks. FRAME_LINES = VS_WIDTH + V_BACK + V_DISP + V_FRONT.
- Defaults give 1424 x 508 = 723392 clocks per frame.
- Reset: state IDLE, counters 0. dvp_vsync=0, dvp_href=0, dvp_data=0, frame_done=0, frame_cnt=0.
- All outputs are registered.
- FSM states: IDLE, VSYNC, VBACK, ACTIVE, VFRONT.
- h_cnt counts 0..LINE_LEN-1 in every non-IDLE state. v_cnt counts lines within the current state.
- IDLE: outputs low. If en=1 at edge k, go to VSYNC with h_cnt=0. dvp_vsync=1 from the cycle after edge k.
- Pattern capture: pattern_sel is latched on IDLE->VSYNC and on every frame restart. Mid-frame changes are ignored until the next frame.
- VSYNC: dvp_vsync=1 for VS_WIDTH*LINE_LEN clocks, then VBACK.
- VBACK: all outputs low for V_BACK lines, then ACTIVE.
- ACTIVE: V_DISP lines. dvp_href=1 for h_cnt in 0..2*H_DISP-1, then 0 for H_BLANK clocks.
  - Pixel x = h_cnt>>1. y = active line index.
  - dvp_data = pix[15:8] when h_cnt[0]=0, pix[7:0] when h_cnt[0]=1.
  - dvp_data = 0 whenever href=0.
- VFRONT: all outputs low for V_FRONT lines.
- End of frame, on the last VFRONT clock:
  - frame_done=1 for exactly that cycle.
  - frame_cnt increments on the same edge; 255 wraps to 0.
  - Next state is VSYNC if en=1 (back-to-back, zero gap clocks), else IDLE.
- en deasserted mid-frame: the current frame completes unchanged; the FSM then goes to IDLE.
- Patterns (RGB565):
  - 0: 8 equal bars, bar = x / (H_DISP/8). Bar colours in order: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
  - 1: g = x[7:0]; pix = {g[7:3], g[7:2], g[7:3]}.
  - 2: pix = (x[5]^y[5]) ? FFFF : 0000.
  - 3: pix = F800.
- Reset mid-operation (any state): next cycle matches the reset values. No frame_done is emitted for the aborted frame.
- Counter widths: h_cnt sized for LINE_LEN-1; v_cnt sized for the largest of VS_WIDTH, V_BACK, V_DISP, V_FRONT. No overflow for defaults.

Test Plan:
Small configuration H_DISP=8, V_DISP=4, H_BLANK=4, VS_WIDTH=1, V_BACK=2, V_FRONT=1 gives LINE_LEN=20 and 160 clocks per frame.
1. Reset, en=0 for 50 clocks -> all outputs 0, frame_cnt=0, no activity.
2. en=1 for one frame, pattern 0 -> vsync high for clocks 1..20 after en. First href rises at clock 61. Each of 4 lines carries 16 href-high bytes, then 4 low. Bytes are FF FF FF E0 07 FF 07 E0 F8 1F F8 00 00 1F 00 00. frame_done at clock 160. frame_cnt=1.
3. pattern_sel changed 0->3 during ACTIVE -> current frame stays colour bars. Next frame's bytes are all F8 00.
4. en dropped at line 3 of frame -> frame finishes at 160 clocks with frame_done=1, then IDLE. No vsync follows.
5. rst pulsed during ACTIVE with href=1 -> next cycle href=0, data=0, frame_cnt=0. No frame_done. Restart with en=1 gives correct timing from VSYNC.
6. en held high for 257 frames -> frames are back-to-back with no gap clocks. frame_cnt wraps 255->0 at frame 256 and reads 1 after frame 257. Exactly one frame_done per frame.

Source files
------------

// File: rtl/dvp_frame_gen.sv
// DVP (OV5640-style) test-pattern transmitter: vsync/href/RGB565 byte stream.
// Replaces the sensor at the capture input; runs in the pixel-clock domain.
module dvp_frame_gen #(
    parameter int H_DISP   = 640,
    parameter int V_DISP   = 480,
    parameter int H_BLANK  = 144,
    parameter int VS_WIDTH = 4,
    parameter int V_BACK   = 16,
    parameter int V_FRONT  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] pattern_sel,
    output logic       dvp_vsync,
    output logic       dvp_href,
    output logic [7:0] dvp_data,
    output logic       frame_done,
    output logic [7:0] frame_cnt
);

    localparam int LINE_LEN = 2 * H_DISP + H_BLANK;

    localparam int V_MAX_A = (VS_WIDTH > V_BACK) ? VS_WIDTH : V_BACK;
    localparam int V_MAX_B = (V_DISP > V_FRONT) ? V_DISP : V_FRONT;
    localparam int V_MAX   = (V_MAX_A > V_MAX_B) ? V_MAX_A : V_MAX_B;

    localparam int HW = $clog2(LINE_LEN);
    localparam int VW = $clog2(V_MAX + 1);

    // Colour bars are tracked with a small counter pair instead of a divider.
    localparam int BAR_W = H_DISP / 8;
    localparam int BW    = $clog2(BAR_W + 1);

    localparam logic [HW-1:0] H_LAST  = HW'(LINE_LEN - 1);
    localparam logic [HW-1:0] H_ACT   = HW'(2 * H_DISP);
    localparam logic [VW-1:0] VS_LAST = VW'(VS_WIDTH - 1);
    localparam logic [VW-1:0] VB_LAST = VW'(V_BACK - 1);
    localparam logic [VW-1:0] VA_LAST = VW'(V_DISP - 1);
    localparam logic [VW-1:0] VF_LAST = VW'(V_FRONT - 1);
    localparam logic [BW-1:0] B_LAST  = BW'(BAR_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        VSYNC,
        VBACK,
        ACTIVE,
        VFRONT
    } state_t;

    // Position registers describe the clock currently shown on the outputs.
    state_t         state_q, state_d;
    logic [HW-1:0]  h_q, h_d;
    logic [VW-1:0]  v_q, v_d;
    logic [1:0]     pat_q, pat_d;
    logic [2:0]     bar_q, bar_d;
    logic [BW-1:0]  bpix_q, bpix_d;

    logic           vsync_q, vsync_d;
    logic           href_q, href_d;
    logic [7:0]     data_q, data_d;
    logic           fdone_q, fdone_d;
    logic [7:0]     fcnt_q, fcnt_d;

    logic [VW-1:0]  v_last;
    logic           line_end;
    logic           state_end;
    logic [15:0]    pix;
    logic [15:0]    bar_rgb;
    logic [5:0]     g6;
    logic           chk;

    // Next position in the frame: line/clock counters and state sequencing.
    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        v_d     = v_q;
        pat_d   = pat_q;
        v_last  = VS_LAST;

        unique case (state_q)
            VSYNC:   v_last = VS_LAST;
            VBACK:   v_last = VB_LAST;
            ACTIVE:  v_last = VA_LAST;
            VFRONT:  v_last = VF_LAST;
            default: v_last = VS_LAST;
        endcase

        line_end  = (h_q == H_LAST);
        state_end = line_end && (v_q == v_last);

        if (state_q == IDLE) begin
            h_d = '0;
            v_d = '0;
            if (en) begin
                state_d = VSYNC;
                pat_d   = pattern_sel;
            end
        end else begin
            h_d = line_end ? '0 : h_q + 1'b1;

            if (state_end) begin
                v_d = '0;
            end else if (line_end) begin
                v_d = v_q + 1'b1;
            end

            if (state_end) begin
                unique case (state_q)
                    VSYNC:  state_d = VBACK;
                    VBACK:  state_d = ACTIVE;
                    ACTIVE: state_d = VFRONT;
                    VFRONT: begin
                        // Back-to-back frames re-latch the pattern here.
                        if (en) begin
                            state_d = VSYNC;
                            pat_d   = pattern_sel;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    // Bar index and pixel-within-bar for the pixel x = h_d >> 1.
    always_comb begin
        bar_d  = bar_q;
        bpix_d = bpix_q;
        if (h_d == '0) begin
            bar_d  = '0;
            bpix_d = '0;
        end else if (h_q[0]) begin
            if (bpix_q == B_LAST) begin
                bpix_d = '0;
                bar_d  = bar_q + 1'b1;
            end else begin
                bpix_d = bpix_q + 1'b1;
            end
        end
    end

    // Pixel colour for the next position, from the latched pattern.
    always_comb begin
        bar_rgb = 16'h0000;
        unique case (bar_d)
            3'd0: bar_rgb = 16'hFFFF;
            3'd1: bar_rgb = 16'hFFE0;
            3'd2: bar_rgb = 16'h07FF;
            3'd3: bar_rgb = 16'h07E0;
            3'd4: bar_rgb = 16'hF81F;
            3'd5: bar_rgb = 16'hF800;
            3'd6: bar_rgb = 16'h001F;
            3'd7: bar_rgb = 16'h0000;
            default: bar_rgb = 16'h0000;
        endcase

        // g6 is x[7:2]; the 5-bit channels reuse its top five bits.
        g6  = 6'(h_d >> 3);
        chk = (((32'(h_d) >> 6) ^ (32'(v_d) >> 5)) & 32'd1) != 32'd0;

        pix = 16'h0000;
        unique case (pat_q)
            2'd0: pix = bar_rgb;
            2'd1: pix = {g6[5:1], g6, g6[5:1]};
            2'd2: pix = chk ? 16'hFFFF : 16'h0000;
            2'd3: pix = 16'hF800;
            default: pix = 16'h0000;
        endcase
    end

    // Output values that belong to the next position.
    always_comb begin
        vsync_d = (state_d == VSYNC);
        href_d  = (state_d == ACTIVE) && (h_d < H_ACT);
        data_d  = 8'h00;
        if (href_d) begin
            data_d = h_d[0] ? pix[7:0] : pix[15:8];
        end
        fdone_d = (state_d == VFRONT) && (h_d == H_LAST) &&
                  (v_d == VF_LAST);
        fcnt_d  = fcnt_q + 8'(fdone_d);
    end

    // Frame FSM with registered outputs; synchronous reset aborts any frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            h_q     <= '0;
            v_q     <= '0;
            pat_q   <= '0;
            bar_q   <= '0;
            bpix_q  <= '0;
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            data_q  <= 8'h00;
            fdone_q <= 1'b0;
            fcnt_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            v_q     <= v_d;
            pat_q   <= pat_d;
            bar_q   <= bar_d;
            bpix_q  <= bpix_d;
            vsync_q <= vsync_d;
            href_q  <= href_d;
            data_q  <= data_d;
            fdone_q <= fdone_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign dvp_vsync  = vsync_q;
    assign dvp_href   = href_q;
    assign dvp_data   = data_q;
    assign frame_done = fdone_q;
    assign frame_cnt  = fcnt_q;

endmodule
